hwpe_ctrl_periph_arbiter: RTL and testbench
===========================================

// Module: hwpe_ctrl_periph_arbiter
// PURPOSE
//  N-to-1 arbiter for the HWPE peripheral (req/gnt/r_valid) control bus, parametrised in port count, widths and depth.
//  Merges NB_IN master ports onto one slave port with fair round-robin arbitration.
//  Tracks up to MAX_OUTSTANDING granted transactions and routes each r_valid/r_data/r_id back to its issuer, in order.
//  Sits between several cores/DMA masters and one hwpe_ctrl register slave.
// PARAMETERS
//  NB_IN            4   number of master (input) ports, >=2
//  ADDR_WIDTH       32  address width
//  DATA_WIDTH       32  data width; be width = DATA_WIDTH/8
//  ID_WIDTH         8   transaction id width, forwarded unchanged
//  MAX_OUTSTANDING  4   granted-but-unanswered transactions, >=1
// PORTS
//  clk_i         in   1                  clock
//  rst_i         in   1                  async reset, active-high
//  in_req_i      in   NB_IN              per-master request
//  in_gnt_o      out  NB_IN              per-master grant
//  in_add_i      in   NB_IN*ADDR_WIDTH   per-master address
//  in_wen_i      in   NB_IN              1=write, 0=read
//  in_be_i       in   NB_IN*DATA_WIDTH/8 byte enables
//  in_data_i     in   NB_IN*DATA_WIDTH   write data
//  in_id_i       in   NB_IN*ID_WIDTH     request id
//  in_r_data_o   out  NB_IN*DATA_WIDTH   response data (broadcast)
//  in_r_valid_o  out  NB_IN              per-master response valid
//  in_r_id_o     out  NB_IN*ID_WIDTH     response id (broadcast)
//  out_req_o / out_gnt_i / out_add_o / out_wen_o / out_be_o / out_data_o / out_id_o   slave request side
//  out_r_data_i / out_r_valid_i / out_r_id_i                                          slave response side
//  busy_o        out  1                  >=1 transaction outstanding
//  err_o         out  1                  sticky: r_valid received with nothing outstanding
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer=0; lock cleared; route FIFO empty; err_o=0.
//  Protocol: master holds req and payload stable until gnt; every granted request yields exactly one r_valid, >=1 cycle later, in grant order.
//  Arbitration: winner = first requester at or after rr pointer (wrap modulo NB_IN); combinational req/payload path to out_*.
//  Lock: if out_req_o=1 and out_gnt_i=0, winner index registered and held until its handshake; no re-arbitration meanwhile.
//  Handshake: in_gnt_o[w] = out_gnt_i & out_req_o & !fifo_full; out_req_o forced 0 while fifo_full.
//  On handshake: push w into route FIFO; rr pointer <= (w+1) mod NB_IN; lock released.
//  Response: out_r_valid_i pops FIFO head h; in_r_valid_o[h]=1 same cycle (0 latency); r_data/r_id broadcast to all ports.
//  Simultaneous push+pop: allowed at any occupancy incl. full (occupancy unchanged). Full check uses pre-pop state (no bypass).
//  Empty FIFO + out_r_valid_i: response dropped, no in_r_valid_o, err_o<=1 until reset.
//  busy_o = FIFO not empty (registered occupancy).
//  Reset mid-operation: FIFO, lock, pointer cleared; late responses to pre-reset requests hit err_o.
//  Widths: pointer/index $clog2(NB_IN); occupancy counter $clog2(MAX_OUTSTANDING+1); wrap on power-of-2 and non-power-of-2 depths.
// STRUCTURE
//  Package hwpe_ctrl_package: periph request/response struct typedefs parametrised via localparams.
//  Sub-module hwpe_ctrl_periph_route_fifo: sync FIFO of $clog2(NB_IN)-bit indices, depth MAX_OUTSTANDING, full/empty/count.
//  Top: rr pointer, lock reg, priority select, muxes, error flag.
// TESTING
//  1. Single master 0 read, out_gnt_i=1, r_valid 1 cycle later, r_data=0xCAFE0001 -> only in_r_valid_o[0]=1, r_id echoes id.
//  2. All 4 masters req continuously, out_gnt_i=1 -> grants in order 0,1,2,3,0...; each master exactly 25% of 400 grants.
//  3. out_gnt_i low 5 cycles while master 2 waits, master 1 raises req -> out_add_o stays master 2's; master 2 granted first.
//  4. 4 grants, no responses, MAX_OUTSTANDING=4 -> out_req_o=0, busy_o=1; one r_valid pops + new grant same cycle accepted.
//  5. Interleaved masters 3,0,2 granted, responses 0xA,0xB,0xC -> delivered to 3,0,2 respectively in that order.
//  6. r_valid with empty FIFO -> no in_r_valid_o, err_o=1; rst_i pulse mid-burst -> all outputs 0, err_o cleared.

Source files
------------

// File: rtl/hwpe_ctrl_periph_arbiter_pkg.sv
// Shared types and helpers for the HWPE peripheral control bus arbiter.
// Struct widths describe the default bus configuration.
package hwpe_ctrl_package;

  localparam int PERIPH_ADDR_WIDTH = 32;
  localparam int PERIPH_DATA_WIDTH = 32;
  localparam int PERIPH_ID_WIDTH   = 8;
  localparam int PERIPH_BE_WIDTH   = PERIPH_DATA_WIDTH / 8;

  typedef struct packed {
    logic                         req;
    logic [PERIPH_ADDR_WIDTH-1:0] add;
    logic                         wen;
    logic [PERIPH_BE_WIDTH-1:0]   be;
    logic [PERIPH_DATA_WIDTH-1:0] data;
    logic [PERIPH_ID_WIDTH-1:0]   id;
  } hwpe_ctrl_periph_req_t;

  typedef struct packed {
    logic                         r_valid;
    logic [PERIPH_DATA_WIDTH-1:0] r_data;
    logic [PERIPH_ID_WIDTH-1:0]   r_id;
  } hwpe_ctrl_periph_resp_t;

  // Increment with wrap at an arbitrary (not necessarily power-of-2) modulus.
  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_periph_route_fifo.sv
// Small synchronous FIFO of master indices; head is readable combinationally
// so a response can be routed in the same cycle it arrives.
module hwpe_ctrl_periph_route_fifo
  import hwpe_ctrl_package::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot, so a push on a full FIFO is still accepted then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = PTR_W'(wrap_inc(int'(wr_ptr_q), DEPTH));
    if (do_pop)  rd_ptr_d = PTR_W'(wrap_inc(int'(rd_ptr_q), DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hwpe_ctrl_periph_arbiter.sv
// Round-robin N-to-1 arbiter for the HWPE peripheral bus, with in-order
// routing of responses back to the issuing master.
module hwpe_ctrl_periph_arbiter
  import hwpe_ctrl_package::*;
#(
  parameter int NB_IN           = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_IN-1:0]               in_req_i,
  output logic [NB_IN-1:0]               in_gnt_o,
  input  logic [NB_IN*ADDR_WIDTH-1:0]    in_add_i,
  input  logic [NB_IN-1:0]               in_wen_i,
  input  logic [NB_IN*DATA_WIDTH/8-1:0]  in_be_i,
  input  logic [NB_IN*DATA_WIDTH-1:0]    in_data_i,
  input  logic [NB_IN*ID_WIDTH-1:0]      in_id_i,
  output logic [NB_IN*DATA_WIDTH-1:0]    in_r_data_o,
  output logic [NB_IN-1:0]               in_r_valid_o,
  output logic [NB_IN*ID_WIDTH-1:0]      in_r_id_o,
  output logic                           out_req_o,
  input  logic                           out_gnt_i,
  output logic [ADDR_WIDTH-1:0]          out_add_o,
  output logic                           out_wen_o,
  output logic [DATA_WIDTH/8-1:0]        out_be_o,
  output logic [DATA_WIDTH-1:0]          out_data_o,
  output logic [ID_WIDTH-1:0]            out_id_o,
  input  logic [DATA_WIDTH-1:0]          out_r_data_i,
  input  logic                           out_r_valid_i,
  input  logic [ID_WIDTH-1:0]            out_r_id_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int IDX_W = $clog2(NB_IN);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [IDX_W-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, win_idx, head_idx;
  logic             lock_q, lock_d, err_q, err_d;
  logic             win_found, handshake, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Scan from the farthest offset down so the nearest requester at/after rr wins.
  always_comb begin : priority_select
    int cand;
    cand      = 0;
    win_idx   = lock_idx_q;
    win_found = lock_q;
    if (!lock_q) begin
      for (int i = NB_IN - 1; i >= 0; i--) begin
        cand = int'(rr_q) + i;
        if (cand >= NB_IN) cand = cand - NB_IN;
        if (in_req_i[cand]) begin
          win_idx   = IDX_W'(cand);
          win_found = 1'b1;
        end
      end
    end
  end

  assign out_req_o  = win_found & ~fifo_full;
  assign handshake  = out_req_o & out_gnt_i;
  assign out_add_o  = win_found ? in_add_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign out_wen_o  = win_found ? in_wen_i[win_idx] : 1'b0;
  assign out_be_o   = win_found ? in_be_i[int'(win_idx)*BE_W +: BE_W] : '0;
  assign out_data_o = win_found ? in_data_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign out_id_o   = win_found ? in_id_i[int'(win_idx)*ID_WIDTH +: ID_WIDTH] : '0;

  for (genvar gi = 0; gi < NB_IN; gi++) begin : gen_port
    assign in_gnt_o[gi]     = handshake & (win_idx == IDX_W'(gi));
    assign in_r_valid_o[gi] = out_r_valid_i & ~fifo_empty & (head_idx == IDX_W'(gi));
    assign in_r_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = out_r_data_i;
    assign in_r_id_o[gi*ID_WIDTH +: ID_WIDTH]       = out_r_id_i;
  end

  assign busy_o = (fifo_count != '0);
  assign err_o  = err_q;

  // A stalled request pins the winner so the slave sees a stable payload.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    err_d      = err_q | (out_r_valid_i & fifo_empty);
    if (handshake) begin
      lock_d = 1'b0;
      rr_d   = IDX_W'(wrap_inc(int'(win_idx), NB_IN));
    end else if (out_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = win_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  hwpe_ctrl_periph_route_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) i_route_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (win_idx),
    .pop_i   (out_r_valid_i),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_hwpe_ctrl_periph_arbiter.sv
// Self-checking bench: table of arbitration vectors plus hand-written
// sequences for stall/lock, FIFO-full, routing order, error and reset.
module tb_hwpe_ctrl_periph_arbiter;

  localparam int NB = 4, AW = 32, DW = 32, IW = 8, MO = 4, BW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NB-1:0]     in_req_i, in_gnt_o, in_wen_i, in_r_valid_o;
  logic [NB*AW-1:0]  in_add_i;
  logic [NB*BW-1:0]  in_be_i;
  logic [NB*DW-1:0]  in_data_i, in_r_data_o;
  logic [NB*IW-1:0]  in_id_i, in_r_id_o;
  logic              out_req_o, out_gnt_i, out_wen_o, out_r_valid_i, busy_o, err_o;
  logic [AW-1:0]     out_add_o;
  logic [BW-1:0]     out_be_o;
  logic [DW-1:0]     out_data_o, out_r_data_i;
  logic [IW-1:0]     out_id_o, out_r_id_i;

  always #5 clk_i = ~clk_i;

  hwpe_ctrl_periph_arbiter #(
    .NB_IN(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
    .in_be_i(in_be_i), .in_data_i(in_data_i), .in_id_i(in_id_i),
    .in_r_data_o(in_r_data_o), .in_r_valid_o(in_r_valid_o), .in_r_id_o(in_r_id_o),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o), .out_wen_o(out_wen_o),
    .out_be_o(out_be_o), .out_data_o(out_data_o), .out_id_o(out_id_o),
    .out_r_data_i(out_r_data_i), .out_r_valid_i(out_r_valid_i), .out_r_id_i(out_r_id_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic [7:0]  id;
  } resp_t;

  typedef struct {
    logic [3:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    int          exp_w;
    logic        exp_req;
  } vec_t;

  int    n_cmp = 0, n_fail = 0;
  int    route_q[$];
  resp_t sb_q[$];
  logic  err_model = 1'b0;
  int    gnt_cnt[NB];
  vec_t  vecs[8];

  function automatic logic [AW-1:0] m_add(input int m);  return 32'h4000_0000 + 32'(m * 16); endfunction
  function automatic logic [IW-1:0] m_id(input int m);   return 8'h10 + 8'(m);             endfunction
  function automatic logic [DW-1:0] m_data(input int m); return 32'hD000_0000 + 32'(m);    endfunction
  function automatic logic [BW-1:0] m_be(input int m);   return 4'(1 << m);                endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, model the route FIFO, check at negedge, advance.
  task automatic cycle(input string name, input logic [3:0] req, input logic gnt,
                       input logic rv, input logic [31:0] rd, input int exp_w, input logic exp_req);
    int            occ;
    logic          drop;
    resp_t         e;
    logic [NB-1:0] exp_gnt, oh;
    occ  = route_q.size();
    drop = 1'b0;
    in_req_i = req; out_gnt_i = gnt; out_r_valid_i = rv; out_r_data_i = rd; out_r_id_i = 8'hEE;
    if (rv) begin
      if (occ > 0) begin
        e.port = route_q.pop_front();
        e.data = rd;
        e.id   = m_id(e.port);
        out_r_id_i = e.id;
        sb_q.push_back(e);
      end else begin
        drop = 1'b1;
      end
    end
    exp_gnt = '0;
    if (exp_req && gnt) exp_gnt[exp_w] = 1'b1;
    @(negedge clk_i);
    chk({name, ":in_gnt"}, 128'(in_gnt_o), 128'(exp_gnt));
    chk({name, ":out_req"}, 128'(out_req_o), 128'(exp_req));
    chk({name, ":busy"}, 128'(busy_o), 128'(occ != 0));
    chk({name, ":err"}, 128'(err_o), 128'(err_model));
    if (exp_req) begin
      chk({name, ":out_add"}, 128'(out_add_o), 128'(m_add(exp_w)));
      chk({name, ":out_id"}, 128'(out_id_o), 128'(m_id(exp_w)));
      chk({name, ":out_data"}, 128'(out_data_o), 128'(m_data(exp_w)));
      chk({name, ":out_be"}, 128'(out_be_o), 128'(m_be(exp_w)));
      chk({name, ":out_wen"}, 128'(out_wen_o), 128'(exp_w % 2));
    end
    for (int m = 0; m < NB; m++) gnt_cnt[m] += int'(in_gnt_o[m]);
    if (exp_gnt != '0) route_q.push_back(exp_w);
    if (rv && !drop) begin
      e = sb_q.pop_front();
      oh = '0;
      oh[e.port] = 1'b1;
      chk({name, ":r_valid"}, 128'(in_r_valid_o), 128'(oh));
      chk({name, ":r_data"}, 128'(in_r_data_o), {NB{e.data}});
      chk({name, ":r_id"}, 128'(in_r_id_o), 128'({NB{e.id}}));
    end else begin
      chk({name, ":r_valid_none"}, 128'(in_r_valid_o), 128'(0));
    end
    if (drop) err_model = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    in_req_i = '0; out_gnt_i = 1'b0; out_r_valid_i = 1'b0; out_r_data_i = '0; out_r_id_i = '0;
    for (int m = 0; m < NB; m++) begin
      in_add_i[m*AW +: AW]  = m_add(m);
      in_id_i[m*IW +: IW]   = m_id(m);
      in_data_i[m*DW +: DW] = m_data(m);
      in_be_i[m*BW +: BW]   = m_be(m);
      in_wen_i[m]           = m[0];
      gnt_cnt[m]            = 0;
    end

    vecs[0] = '{4'b0001, 1'b1, 1'b0, 32'h0,        0, 1'b1};
    vecs[1] = '{4'b0000, 1'b1, 1'b1, 32'hCAFE0001, -1, 1'b0};
    vecs[2] = '{4'b1111, 1'b1, 1'b0, 32'h0,        1, 1'b1};
    vecs[3] = '{4'b1111, 1'b1, 1'b1, 32'h11,       2, 1'b1};
    vecs[4] = '{4'b1001, 1'b1, 1'b1, 32'h12,       3, 1'b1};
    vecs[5] = '{4'b1010, 1'b1, 1'b1, 32'h13,       1, 1'b1};
    vecs[6] = '{4'b1001, 1'b1, 1'b1, 32'h14,       3, 1'b1};
    vecs[7] = '{4'b0000, 1'b1, 1'b1, 32'h15,       -1, 1'b0};

    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("reset:in_gnt", 128'(in_gnt_o), 128'(0));
    chk("reset:r_valid", 128'(in_r_valid_o), 128'(0));
    chk("reset:out_req", 128'(out_req_o), 128'(0));
    chk("reset:out_add", 128'(out_add_o), 128'(0));
    chk("reset:busy", 128'(busy_o), 128'(0));
    chk("reset:err", 128'(err_o), 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++)
      cycle($sformatf("vec%0d", i), vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rd,
            vecs[i].exp_w, vecs[i].exp_req);

    // Fairness: every master requesting, slave always ready.
    for (int m = 0; m < NB; m++) gnt_cnt[m] = 0;
    for (int k = 0; k < 400; k++)
      cycle("rr", 4'b1111, 1'b1, k > 0, 32'(k), k % NB, 1'b1);
    cycle("rr_drain", 4'b0000, 1'b0, 1'b1, 32'h400, -1, 1'b0);
    for (int m = 0; m < NB; m++) chk($sformatf("rr_share%0d", m), 128'(gnt_cnt[m]), 128'(100));

    // Stalled slave: master 2 stays locked while master 1 joins.
    cycle("lock0", 4'b0100, 1'b0, 1'b0, 0, 2, 1'b1);
    for (int k = 1; k < 5; k++) cycle($sformatf("lock%0d", k), 4'b0110, 1'b0, 1'b0, 0, 2, 1'b1);
    cycle("lock_gnt2", 4'b0110, 1'b1, 1'b0, 0, 2, 1'b1);
    cycle("lock_gnt1", 4'b0010, 1'b1, 1'b1, 32'h55, 1, 1'b1);
    cycle("lock_drain", 4'b0000, 1'b0, 1'b1, 32'h56, -1, 1'b0);

    // FIFO full: four outstanding, then pop-while-full and push+pop.
    cycle("fill_a", 4'b1111, 1'b1, 1'b0, 0, 2, 1'b1);
    cycle("fill_b", 4'b1111, 1'b1, 1'b0, 0, 3, 1'b1);
    cycle("fill_c", 4'b1111, 1'b1, 1'b0, 0, 0, 1'b1);
    cycle("fill_d", 4'b1111, 1'b1, 1'b0, 0, 1, 1'b1);
    cycle("full_stall", 4'b1111, 1'b1, 1'b0, 0, -1, 1'b0);
    cycle("full_pop", 4'b1111, 1'b1, 1'b1, 32'h60, -1, 1'b0);
    cycle("pushpop_a", 4'b1111, 1'b1, 1'b1, 32'h61, 2, 1'b1);
    cycle("pushpop_b", 4'b1111, 1'b1, 1'b1, 32'h62, 3, 1'b1);
    for (int k = 0; k < 3; k++) cycle($sformatf("full_drain%0d", k), 4'b0000, 1'b0, 1'b1, 32'h63 + 32'(k), -1, 1'b0);

    // Interleaved issue 3,0,2; responses routed in grant order.
    cycle("order_g3", 4'b1000, 1'b1, 1'b0, 0, 3, 1'b1);
    cycle("order_g0", 4'b0001, 1'b1, 1'b0, 0, 0, 1'b1);
    cycle("order_g2", 4'b0100, 1'b1, 1'b0, 0, 2, 1'b1);
    cycle("order_rA", 4'b0000, 1'b0, 1'b1, 32'hA, -1, 1'b0);
    cycle("order_rB", 4'b0000, 1'b0, 1'b1, 32'hB, -1, 1'b0);
    cycle("order_rC", 4'b0000, 1'b0, 1'b1, 32'hC, -1, 1'b0);

    // Stray response, then reset in the middle of a burst.
    cycle("stray", 4'b0000, 1'b0, 1'b1, 32'hDEAD, -1, 1'b0);
    cycle("burst_a", 4'b1111, 1'b1, 1'b0, 0, 3, 1'b1);
    cycle("burst_b", 4'b1111, 1'b1, 1'b0, 0, 0, 1'b1);
    rst_i = 1'b1;
    in_req_i = '0; out_gnt_i = 1'b0; out_r_valid_i = 1'b0; out_r_data_i = '0; out_r_id_i = '0;
    @(negedge clk_i);
    chk("midrst:in_gnt", 128'(in_gnt_o), 128'(0));
    chk("midrst:r_valid", 128'(in_r_valid_o), 128'(0));
    chk("midrst:out_req", 128'(out_req_o), 128'(0));
    chk("midrst:busy", 128'(busy_o), 128'(0));
    chk("midrst:err", 128'(err_o), 128'(0));
    route_q.delete();
    err_model = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    cycle("late_resp", 4'b0000, 1'b0, 1'b1, 32'hBEEF, -1, 1'b0);
    cycle("err_sticky", 4'b0000, 1'b0, 1'b0, 0, -1, 1'b0);
    cycle("err_hold", 4'b0001, 1'b1, 1'b0, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
